gray_to_rgb: RTL



---
 rtl/gray_to_rgb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/gray_to_rgb.sv
// -----------------------------------------------------------------------------
// gray_to_rgb
//   Output stage of the edge-detection pipeline. Pops 8-bit grayscale/edge
//   pixels from an upstream first-word-fall-through FIFO and pushes 24-bit
//   {g,g,g} RGB pixels into the image-writer FIFO at one pixel per clock,
//   using a single holding register. Tracks the raster position of the next
//   pixel to be written and pulses frame_done for one cycle after the last
//   pixel of each WIDTH x HEIGHT frame.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high; clears holding register, counters
//   in_empty   : upstream FIFO empty
//   in_dout    : upstream FIFO head data (valid while in_empty=0)
//   in_rd_en   : pop upstream FIFO this cycle
//   out_full   : downstream FIFO full
//   out_wr_en  : push downstream FIFO this cycle
//   out_din    : pushed pixel {R,G,B} = {g,g,g}, zero when nothing is held
//   col, row   : column / row of the next pixel to be written
//   frame_done : one-cycle pulse after the frame's last pixel is written
// -----------------------------------------------------------------------------
module gray_to_rgb #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_empty,
  input  logic [7:0]    in_dout,
  output logic          in_rd_en,
  input  logic          out_full,
  output logic          out_wr_en,
  output logic [23:0]   out_din,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic          hold_valid_q, hold_valid_d;
  logic [7:0]    hold_data_q,  hold_data_d;
  logic [CW-1:0] col_q,        col_d;
  logic [RW-1:0] row_q,        row_d;
  logic          frame_done_q, frame_done_d;
  logic          rd_s;
  logic          wr_s;

  // Gray-to-RGB is plain replication of the luma byte into all three channels.
  function automatic logic [23:0] replicate(input logic [7:0] g);
    return {g, g, g};
  endfunction

  // Handshake: write whenever something is held and downstream has room;
  // read when the register is empty or is draining in this same cycle.
  always_comb begin
    wr_s = hold_valid_q & ~out_full;
    rd_s = ~in_empty & (~hold_valid_q | ~out_full);
  end

  assign in_rd_en   = rd_s;
  assign out_wr_en  = wr_s;
  assign out_din    = hold_valid_q ? replicate(hold_data_q) : 24'h000000;
  assign col        = col_q;
  assign row        = row_q;
  assign frame_done = frame_done_q;

  // Holding register next state: a pop refills (even while draining), a
  // write without a pop empties, otherwise the register holds.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (rd_s) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_dout;
    end else if (wr_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Raster position advances per written pixel; the frame-done pulse is
  // raised by the write of the last pixel and therefore shows one cycle later.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (wr_s) begin
      if (col_q == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d        = {RW{1'b0}};
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  // State registers; reset discards any held pixel and restarts the raster.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
